ixc_osf_evq: RTL and testbench

IXC_OSF_EVQ -- requirements
Module: ixc_osf_evq

---
 rtl/ixc_osf_evq.sv | 121 ++++++++++++
 tb/tb_ixc_osf_evq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_osf_evq.sv
// Event queue: edge-detects NEV inputs and round-robins them into a DEPTH-entry {id, ts} queue.
// Edge to ev_vld takes 2 cycles; while the queue is full events wait in pend and repeats coalesce.
module ixc_osf_evq #(
    parameter int NEV   = 8,
    parameter int DEPTH = 8,
    parameter int TSW   = 16,
    localparam int IDW  = $clog2(NEV)
) (
    input  logic             uclk,
    input  logic             rst_n,
    input  logic [NEV-1:0]   ev_in,
    input  logic             flush,
    output logic             ev_vld,
    input  logic             ev_rdy,
    output logic [IDW-1:0]   ev_id,
    output logic [TSW-1:0]   ev_ts,
    output logic             osf_busy,
    output logic             ev_drop,
    output logic [15:0]      coal_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [TSW-1:0] ts;
    } evEnt_t;

    evEnt_t         mem [DEPTH];
    logic [NEV-1:0] evInQ, pend, edges, grantMask, coalMask, pendNext;
    logic [IDW-1:0] lastGrant, grantIdx, cand;
    logic           grantAny, grant, pop, full, busy, evDrop;
    logic [PW-1:0]  rdPtr, wrPtr;
    logic [PW:0]    count;
    logic [TSW-1:0] ts;
    logic [15:0]    coalCnt, coalNext;
    logic [6:0]     coalAdd;
    logic [16:0]    coalSum;
    int             idx;

    assign edges  = ev_in & ~evInQ;
    assign full   = (count == (PW+1)'(DEPTH));
    assign ev_vld = (count != '0);
    assign pop    = ev_vld & ev_rdy & ~flush;
    assign grant  = grantAny & ~full & ~flush;

    // Round-robin: first pending index strictly after lastGrant, wrapping.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 1; k <= NEV; k++) begin
            idx  = (int'(lastGrant) + k) % NEV;
            cand = IDW'(idx);
            if (!grantAny && pend[cand]) begin
                grantAny = 1'b1;
                grantIdx = cand;
            end
        end
    end

    always_comb begin
        grantMask = '0;
        if (grant) grantMask[grantIdx] = 1'b1;
    end

    // An edge coinciding with its own grant is a fresh event, not a coalesce.
    assign coalMask = edges & pend & ~grantMask & {NEV{~flush}};
    assign pendNext = flush ? edges : ((pend & ~grantMask) | edges);

    always_comb begin
        coalAdd = '0;
        for (int i = 0; i < NEV; i++) coalAdd = coalAdd + 7'(coalMask[i]);
        coalSum  = {1'b0, coalCnt} + 17'(coalAdd);
        coalNext = coalSum[16] ? 16'hFFFF : coalSum[15:0];
    end

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            evInQ     <= '0;
            pend      <= '0;
            lastGrant <= IDW'(NEV - 1);
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            ts        <= '0;
            coalCnt   <= '0;
            evDrop    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            evInQ   <= ev_in;
            ts      <= ts + 1'b1;
            pend    <= pendNext;
            busy    <= (pend != '0) || (count != '0);
            coalCnt <= coalNext;
            if (|coalMask) evDrop <= 1'b1;
            if (grant) lastGrant <= grantIdx;
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (grant) wrPtr <= wrPtr + 1'b1;
                if (pop) rdPtr <= rdPtr + 1'b1;
                if (grant && !pop) count <= count + 1'b1;
                else if (!grant && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge uclk) begin
        if (grant) mem[wrPtr] <= '{id: grantIdx, ts: ts};
    end

    assign ev_id    = ev_vld ? mem[rdPtr].id : '0;
    assign ev_ts    = ev_vld ? mem[rdPtr].ts : '0;
    assign osf_busy = busy;
    assign ev_drop  = evDrop;
    assign coal_cnt = coalCnt;

endmodule

// File: tb/tb_ixc_osf_evq.sv
// Directed bench for ixc_osf_evq: expected {id, ts} entries queued by stimulus, checked on each pop.
module tb_ixc_osf_evq;
    localparam int NEV = 16, DEPTH = 8, TSW = 16, IDW = 4;

    logic             uclk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NEV-1:0]   ev_in = '0;
    logic             flush = 1'b0;
    logic             ev_rdy = 1'b1;
    logic             ev_vld, osf_busy, ev_drop;
    logic [IDW-1:0]   ev_id;
    logic [TSW-1:0]   ev_ts;
    logic [15:0]      coal_cnt;

    ixc_osf_evq #(.NEV(NEV), .DEPTH(DEPTH), .TSW(TSW)) dut (
        .uclk(uclk), .rst_n(rst_n), .ev_in(ev_in), .flush(flush),
        .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_id(ev_id), .ev_ts(ev_ts),
        .osf_busy(osf_busy), .ev_drop(ev_drop), .coal_cnt(coal_cnt)
    );

    always #5 uclk = ~uclk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [TSW-1:0] ts;
    } ent_t;

    ent_t           expQ[$];
    int             nVec = 0;
    int             nMis = 0;
    logic [TSW-1:0] tsM;
    logic [TSW-1:0] t;

    // Reference cycle counter: value of ts in the current cycle.
    always @(posedge uclk or negedge rst_n)
        if (!rst_n) tsM <= '0;
        else tsM <= tsM + 1'b1;

    always @(negedge uclk) begin : monitor
        ent_t e;
        if (rst_n && ev_vld && ev_rdy) begin
            nVec++;
            if (expQ.size() == 0) begin
                nMis++;
                $display("FAIL pop_unexpected: got id=%0d ts=0x%0h, none expected", ev_id, ev_ts);
            end else begin
                e = expQ.pop_front();
                if (ev_id !== e.id || ev_ts !== e.ts) begin
                    nMis++;
                    $display("FAIL pop: got id=%0d ts=0x%0h, expected id=%0d ts=0x%0h",
                             ev_id, ev_ts, e.id, e.ts);
                end
            end
        end
    end

    task automatic tick;
        @(posedge uclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [TSW-1:0] ets);
        expQ.push_back('{id: id, ts: ets});
    endtask

    task automatic pulse(input logic [NEV-1:0] m);
        ev_in = m;
        tick;
        ev_in = '0;
    endtask

    task automatic waitTs(input logic [TSW-1:0] target);
        int n = 0;
        while (tsM != target && n < 70000) begin
            tick;
            n++;
        end
        check("wait_ts", 32'(tsM), 32'(target));
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((ev_vld || osf_busy || expQ.size() != 0) && n < 100) begin
            tick;
            n++;
        end
        check({nm, "_left"}, expQ.size(), 0);
        check({nm, "_vld"}, 32'(ev_vld), 0);
    endtask

    initial begin
        #3;
        check("rst_vld", 32'(ev_vld), 0);
        check("rst_busy", 32'(osf_busy), 0);
        check("rst_id", 32'(ev_id), 0);
        check("rst_ts", 32'(ev_ts), 0);
        check("rst_drop", 32'(ev_drop), 0);
        check("rst_coal", 32'(coal_cnt), 0);
        tick;
        tick;
        rst_n = 1'b1;

        // Single event at ts=10: visible two cycles later carrying ts=11.
        waitTs(16'd10);
        ev_in[3] = 1'b1;
        push(4'd3, 16'd11);
        tick;
        ev_in = '0;
        check("lat_1cyc_vld", 32'(ev_vld), 0);
        tick;
        check("lat_2cyc_vld", 32'(ev_vld), 1);
        check("lat_id", 32'(ev_id), 3);
        tick;
        check("busy_hold", 32'(osf_busy), 1);
        check("single_popped", 32'(ev_vld), 0);
        tick;
        check("busy_fall", 32'(osf_busy), 0);

        // Park last_grant at 7, then simultaneous 0,5,7 and later 1 vs 6.
        t = tsM;
        push(4'd7, t + 16'd1);
        pulse(16'h0080);
        drain("pre7");
        t = tsM;
        push(4'd0, t + 16'd1);
        push(4'd5, t + 16'd2);
        push(4'd7, t + 16'd3);
        pulse(16'h00A1);
        repeat (4) tick;
        t = tsM;
        push(4'd1, t + 16'd1);
        push(4'd6, t + 16'd2);
        pulse(16'h0042);
        drain("rr");

        // Full queue: 10 events with ev_rdy=0, search starts after 6.
        ev_rdy = 1'b0;
        t = tsM;
        push(4'd7, t + 16'd1);
        push(4'd8, t + 16'd2);
        push(4'd9, t + 16'd3);
        push(4'd0, t + 16'd4);
        push(4'd1, t + 16'd5);
        push(4'd2, t + 16'd6);
        push(4'd3, t + 16'd7);
        push(4'd4, t + 16'd8);
        pulse(16'h03FF);
        repeat (12) tick;
        check("full_head_id", 32'(ev_id), 7);
        check("full_head_ts", 32'(ev_ts), 32'(t + 16'd1));
        check("full_busy", 32'(osf_busy), 1);
        tick;
        check("full_head_stable", 32'(ev_id), 7);
        t = tsM;
        push(4'd5, t + 16'd1);
        push(4'd6, t + 16'd2);
        ev_rdy = 1'b1;
        drain("full");
        check("full_no_drop", 32'(ev_drop), 0);

        // Coalesce: queue full of 8..15, then ev_in[2] pends and pulses 3 more times.
        ev_rdy = 1'b0;
        t = tsM;
        for (int i = 0; i < 8; i++) push(IDW'(8 + i), t + 16'(i + 1));
        pulse(16'hFF00);
        repeat (10) tick;
        pulse(16'h0004);
        tick;
        repeat (3) begin
            pulse(16'h0004);
            tick;
        end
        check("coal_cnt", 32'(coal_cnt), 3);
        check("coal_drop", 32'(ev_drop), 1);
        check("coal_head", 32'(ev_id), 8);
        t = tsM;
        push(4'd2, t + 16'd1);
        ev_rdy = 1'b1;
        drain("coal");

        // Timestamp wrap: grants at 0xFFFF and 0x0000.
        waitTs(16'hFFFE);
        ev_in = 16'h0010;
        push(4'd4, 16'hFFFF);
        tick;
        ev_in = 16'h0020;
        push(4'd5, 16'h0000);
        tick;
        ev_in = '0;
        drain("wrap");

        // Flush with 4 queued keeps sticky status.
        ev_rdy = 1'b0;
        pulse(16'h000F);
        repeat (6) tick;
        check("preflush_vld", 32'(ev_vld), 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_vld", 32'(ev_vld), 0);
        check("flush_keep_drop", 32'(ev_drop), 1);
        check("flush_keep_coal", 32'(coal_cnt), 3);
        tick;
        check("flush_busy", 32'(osf_busy), 0);

        // Reset asserted mid-handshake: everything drops asynchronously, no pop seen.
        pulse(16'h0600);
        repeat (4) tick;
        check("prerst_vld", 32'(ev_vld), 1);
        ev_rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(ev_vld), 0);
        check("arst_id", 32'(ev_id), 0);
        check("arst_ts", 32'(ev_ts), 0);
        check("arst_busy", 32'(osf_busy), 0);
        check("arst_drop", 32'(ev_drop), 0);
        check("arst_coal", 32'(coal_cnt), 0);

        // A level already high at reset release is an edge at the first clock.
        ev_in = 16'h1000;
        push(4'd12, 16'd1);
        tick;
        tick;
        rst_n = 1'b1;
        drain("post_reset");
        ev_in = '0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
